// File: rtl/whack_pkg.sv
// Shared types and key-code mapping for the whack-a-mole game core.
package whack_pkg;

    localparam int HOLES = 9;

    typedef logic [3:0] hole_t;

    // Scanner codes: low two bits select the row, bits [3:2] the column.
    localparam logic [4:0] KEY_H0 = 5'h00;
    localparam logic [4:0] KEY_H1 = 5'h04;
    localparam logic [4:0] KEY_H2 = 5'h08;
    localparam logic [4:0] KEY_H3 = 5'h01;
    localparam logic [4:0] KEY_H4 = 5'h05;
    localparam logic [4:0] KEY_H5 = 5'h09;
    localparam logic [4:0] KEY_H6 = 5'h02;
    localparam logic [4:0] KEY_H7 = 5'h06;
    localparam logic [4:0] KEY_H8 = 5'h0A;

    // Returns {valid, hole index}; unmapped codes give valid=0.
    function automatic logic [4:0] code_to_hole(input logic [4:0] code);
        logic [4:0] r;
        r = 5'b0;
        case (code)
            KEY_H0: r = {1'b1, 4'd0};
            KEY_H1: r = {1'b1, 4'd1};
            KEY_H2: r = {1'b1, 4'd2};
            KEY_H3: r = {1'b1, 4'd3};
            KEY_H4: r = {1'b1, 4'd4};
            KEY_H5: r = {1'b1, 4'd5};
            KEY_H6: r = {1'b1, 4'd6};
            KEY_H7: r = {1'b1, 4'd7};
            KEY_H8: r = {1'b1, 4'd8};
            default: r = 5'b0;
        endcase
        return r;
    endfunction

    function automatic logic [HOLES-1:0] hole_to_onehot(input hole_t h);
        logic [HOLES-1:0] oh;
        oh = '0;
        for (int i = 0; i < HOLES; i++) begin
            oh[i] = (h == hole_t'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; dout is the head entry, or 0 while empty.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/hit_event_queue.sv
// Key-scanner front end: resync, press detect, hole decode, repeat lockout, event FIFO.
// Optional macro HIT_EVT_DROPCNT_EN adds the saturating drop_cnt output.
module hit_event_queue
    import whack_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int LOCKOUT_CYCLES = 2_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_ready,
    input  logic [4:0]       key_code,
    output logic             evt_valid,
    output logic [3:0]       evt_hole,
    output logic [HOLES-1:0] evt_onehot,
    input  logic             evt_ready,
    output logic             ovf,
    input  logic             ovf_clr
`ifdef HIT_EVT_DROPCNT_EN
    ,
    output logic [7:0]       drop_cnt
`endif
);

    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);

    logic                    s1, s2, s3;
    logic [4:0]              code_s1, code_s2;
    logic                    press;
    logic [4:0]              code_dec;
    logic                    cand_valid;
    hole_t                   cand_hole;
    hole_t                   last_hole;
    logic [LW-1:0]           lock_cnt;
    logic                    lock_drop;
    logic                    accept;
    logic                    ovf_drop;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [3:0]              fifo_dout;
    logic [$clog2(DEPTH):0]  fifo_count;

    // The code bus is only sampled on the press edge, when it has been stable for two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            code_s1 <= '0;
            code_s2 <= '0;
        end else begin
            s1      <= key_ready;
            s2      <= s1;
            s3      <= s2;
            code_s1 <= key_code;
            code_s2 <= code_s1;
        end
    end

    assign press    = s2 & ~s3;
    assign code_dec = code_to_hole(code_s2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_valid <= 1'b0;
            cand_hole  <= '0;
        end else begin
            cand_valid <= press & code_dec[4];
            cand_hole  <= code_dec[3:0];
        end
    end

    assign lock_drop = cand_valid & (cand_hole == last_hole) & (lock_cnt != '0);
    assign accept    = cand_valid & ~lock_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_hole <= '0;
            lock_cnt  <= '0;
        end else if (accept) begin
            last_hole <= cand_hole;
            lock_cnt  <= LOCK_LOAD;
        end else if (lock_cnt != '0) begin
            lock_cnt <= lock_cnt - LW'(1);
        end
    end

    // Handshake: an entry transfers on every clk edge where evt_valid and evt_ready are both
    // high; evt_valid never depends on evt_ready, and evt_ready while empty is ignored.
    assign pop      = evt_valid & evt_ready;
    assign ovf_drop = accept & fifo_full & ~pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .din   (cand_hole),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign evt_valid  = ~fifo_empty;
    assign evt_hole   = fifo_dout;
    assign evt_onehot = (fifo_count != '0) ? hole_to_onehot(fifo_dout) : '0;

    // Set has priority so an overflow in the clearing cycle is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (ovf_drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

`ifdef HIT_EVT_DROPCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (lock_drop || ovf_drop) begin
            if (ovf_clr) begin
                drop_cnt <= 8'd1;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (ovf_clr) begin
            drop_cnt <= '0;
        end
    end
`endif

endmodule

// File: doc/hit_event_queue.md
Name: hit_event_queue

Overview:
Upstream stage of the whack-a-mole game core. It takes the raw key-scanner output (key_code/key_ready, which toggle in the slow scan-clock domain) and resynchronises it into clk. It then edge-detects presses, maps key codes to hole indices 0..8 and applies a per-press repeat lockout. Accepted hits are buffered in a small FIFO, and the game core pops them with a valid/ready handshake, receiving both a hole index and a one-hot hole vector.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
LOCKOUT_CYCLES, 2_000_000, clk cycles during which a repeat press of the most recently accepted hole is ignored.
HOLES, 9, number of holes; fixed by the 3x3 board.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_ready  in  1  scanner "key held" level; asynchronous to clk
key_code  in  5  scanner key code; stable while key_ready is high
evt_valid  out  1  head FIFO entry is present
evt_hole  out  4  head entry hole index, 0..8
evt_onehot  out  9  head entry as one-hot, bit = hole index
evt_ready  in  1  consumer accepts the head entry
ovf  out  1  sticky overflow flag
ovf_clr  in  1  clears ovf

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Synchroniser flops, edge register, decode stage, FIFO pointers, lockout counter and last_hole all clear.
  - Outputs: evt_valid=0, evt_hole=0, evt_onehot=0, ovf=0.
  - Reset asserted mid-operation discards all queued events.
- Synchronisation:
  - key_ready passes through 2 flops (s1, s2); s3 holds the previous s2.
  - A press is s2 & ~s3.
  - key_code is captured on the same edge, sampled from a 2-flop bus copy. It is valid because the code is stable while ready is high.
- Key-code map (all other codes are discarded, no event):
  - 0x00->0, 0x04->1, 0x08->2
  - 0x01->3, 0x05->4, 0x09->5
  - 0x02->6, 0x06->7, 0x0A->8
- Decode stage (registered):
  - A press with a valid code yields cand_valid, cand_hole.
- Lockout:
  - A candidate is dropped silently if cand_hole==last_hole and lock_cnt!=0.
  - Otherwise the candidate is accepted: last_hole<=cand_hole, lock_cnt<=LOCKOUT_CYCLES-1.
  - lock_cnt decrements to 0 every cycle and saturates at 0.
  - A different hole is always accepted and reloads the counter.
- Latency: press to evt_valid=1 (FIFO initially empty) is 4 clk edges after key_ready first meets setup at s1.
  - Edge 1: s1. Edge 2: s2. Edge 3: decode register. Edge 4: FIFO write.
- FIFO behaviour:
  - Show-ahead: evt_hole/evt_onehot reflect the head entry whenever evt_valid=1, and are 0 when empty.
  - Pop occurs when evt_valid & evt_ready.
  - evt_ready while empty has no effect.
  - Push while full with a pop in the same cycle: both occur, count unchanged, no overflow.
  - Push while full without a pop: the new event is dropped and ovf<=1.
  - Pointers wrap modulo DEPTH; a count register distinguishes full from empty.
- ovf:
  - Sticky, cleared by ovf_clr.
  - If overflow and ovf_clr occur in the same cycle, the set wins.
- A held key produces exactly one event until key_ready falls and rises again.

Optional Feature:
Macro HIT_EVT_DROPCNT_EN.
- Defined: adds output drop_cnt [7:0].
  - Increments on every lockout drop and every overflow drop, saturating at 255.
  - Cleared by ovf_clr; if a drop coincides with ovf_clr, the result is 1.
  - Reset value 0.
- Undefined: drop_cnt port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package whack_pkg contains:
  - HOLES=9.
  - Hole index typedef (4-bit).
  - Key-code constants KEY_H0..KEY_H8.
  - Function code_to_hole returning {valid, index}.
  - Function hole_to_onehot.
- Sub-module sync_fifo: parameterised DEPTH and WIDTH, push/pop/full/empty/count, show-ahead. Instantiated once with WIDTH=4.

Test Plan:
- Reset release, key_code=0x05, key_ready rises -> evt_valid=1 on the 4th edge, evt_hole=4, evt_onehot=9'h010. Pulse evt_ready -> evt_valid=0.
- Press 0x0A twice within LOCKOUT_CYCLES (set to 100 in the bench) -> one event, hole 8. A third press after 100 cycles -> second event.
- Press 0x00 then 0x04 within lockout -> two events, holes 0 then 1, in that order.
- evt_ready=0, six distinct presses with DEPTH=4 -> 4 entries queued, ovf=1, drop_cnt=2 (macro on). Pops return holes in press order.
- FIFO full, press coinciding with a pop cycle -> no ovf, count stays 4, new hole appears last.
- Key code 0x03 or 0x1F pressed -> no event. rst_n pulsed low with 3 entries queued -> evt_valid=0 immediately, queue empty after release.
